alu_issue: RTL and testbench

Issue and writeback sequencer placed directly upstream of the CPU v0 ALU. It holds the 4-entry architectural register file and the NZCV flag register. It accepts one instruction at a time over a valid/ready handshake, drives the ALU operand and op-code inputs, captures the ALU's registered result and flags, then writes back. It is the only writer of architectural register and flag state in v0.

---
 rtl/alu_issue.sv | 113 +++++++++++
 tb/tb_alu_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of the v0 ALU: owns the 4-entry register file
// and the NZCV flags, issues one instruction at a time and writes back two cycles later.
module alu_issue #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 6,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [WORD_W-1:0] instr_imm,
    input  logic              instr_bsel,
    input  logic              instr_we,
    input  logic              instr_fe,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [WORD_W-1:0] alu_res,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [WORD_W-1:0] wb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WORD_W-1:0] dbg_data
);

    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e              state_q;
    logic [WORD_W-1:0]   regs_q [NREG];
    logic [3:0]          flags_q;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [OP_W-1:0]     op_q;
    logic [REG_AW-1:0]   rd_q;
    logic                we_q;
    logic                fe_q;
    logic                wb_valid_q;
    logic                accept;

    // Ready is gated by rst_n so nothing can be accepted on a reset edge.
    assign instr_ready = (state_q == S_IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            // NOTE: the register file is cleared on reset because its contents are
            // architecturally visible (dbg_data must read 0 after reset).
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flags_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            fe_q       <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= regs_q[instr_ra];
                        b_q     <= instr_bsel ? instr_imm : regs_q[instr_rb];
                        op_q    <= instr_op;
                        rd_q    <= instr_rd;
                        we_q    <= instr_we;
                        fe_q    <= instr_fe;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_valid_q <= 1'b1;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    if (we_q) regs_q[rd_q] <= alu_res;
                    if (fe_q) flags_q      <= alu_flags;
                    wb_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    wb_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign flags    = flags_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = rd_q;
    assign wb_data  = alu_res;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered ALU stand-in on the operand side.
module tb_alu_issue;

    localparam int WORD_W = 8;
    localparam int OP_W   = 6;
    localparam int REG_AW = 2;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_ra;
    logic [REG_AW-1:0] instr_rb;
    logic [WORD_W-1:0] instr_imm;
    logic              instr_bsel;
    logic              instr_we;
    logic              instr_fe;
    logic [WORD_W-1:0] alu_a;
    logic [WORD_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [WORD_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic [3:0]        flags;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [WORD_W-1:0] wb_data;
    logic [REG_AW-1:0] dbg_addr;
    logic [WORD_W-1:0] dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue #(.WORD_W(WORD_W), .OP_W(OP_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .instr_imm(instr_imm), .instr_bsel(instr_bsel), .instr_we(instr_we), .instr_fe(instr_fe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flags(alu_flags), .flags(flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: 0=ADD, 1=SUB (C=borrow), 10=PASS B, others -> 0 with Z set.
    // Its ADD reports V only for positive overflow, so 0x80+0x80 yields NZCV=0110.
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            6'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = ~a[7] & ~b[7] & r[7];
            end
            6'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            6'd10: r = b;
            default: return {8'h00, 4'b0100};
        endcase
        return {r, r[7], (r == 8'h00), c, v};
    endfunction

    always_ff @(posedge clk) begin
        {alu_res, alu_flags} <= alu_fn(alu_a, alu_b, alu_op);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] peek(input logic [1:0] a);
        return 8'h00;
    endfunction

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    // Called at a negedge; waits (bounded) for ready, presents one instruction for
    // exactly one accept edge, and returns at the negedge following that edge.
    task automatic issue(input logic [5:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm, input logic bsel,
                         input logic we, input logic fe);
        int waits;
        waits = 0;
        while (!instr_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (!instr_ready) check("issue_timeout", 32'd0, 32'd1);
        instr_op    = op;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        instr_imm   = imm;
        instr_bsel  = bsel;
        instr_we    = we;
        instr_fe    = fe;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_imm   = 8'hEE;
    endtask

    initial begin
        int acc_cnt;
        int wb_cnt;
        int acc_cyc [2];

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_ra    = '0;
        instr_rb    = '0;
        instr_imm   = '0;
        instr_bsel  = 1'b0;
        instr_we    = 1'b0;
        instr_fe    = 1'b0;
        dbg_addr    = '0;

        // Reset: two edges low, then release.
        @(negedge clk);
        check("rst_ready_low", {31'h0, instr_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_low2", {31'h0, instr_ready}, 32'd0);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
        check("rst_flags", {28'h0, flags}, 32'h0);
        for (int i = 0; i < 4; i++) check_reg($sformatf("rst_r%0d", i), i[1:0], 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'h0, instr_ready}, 32'd1);

        // Load via PASS B with detailed cycle timing.
        issue(6'd10, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 1'b1, 1'b0);
        check("ld_e0_ready", {31'h0, instr_ready}, 32'd0);
        check("ld_e0_wbv", {31'h0, wb_valid}, 32'd0);
        check("ld_alu_b", {24'h0, alu_b}, 32'h7F);
        check("ld_alu_op", {26'h0, alu_op}, 32'd10);
        @(negedge clk);
        check("ld_e1_ready", {31'h0, instr_ready}, 32'd0);
        check("ld_e1_wbv", {31'h0, wb_valid}, 32'd1);
        check("ld_wb_data", {24'h0, wb_data}, 32'h7F);
        check("ld_wb_rd", {30'h0, wb_rd}, 32'd1);
        @(negedge clk);
        check("ld_e2_ready", {31'h0, instr_ready}, 32'd1);
        check("ld_e2_wbv", {31'h0, wb_valid}, 32'd0);
        check_reg("ld_r1", 2'd1, 8'h7F);
        check("ld_flags", {28'h0, flags}, 32'h0);

        // ADD overflow, then SUB issued on the very first ready edge.
        issue(6'd0, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 1'b1, 1'b1);
        check("add_alu_a", {24'h0, alu_a}, 32'h7F);
        repeat (2) @(negedge clk);
        check_reg("add_r2", 2'd2, 8'h80);
        check("add_flags", {28'h0, flags}, 32'h9);
        check("b2b_ready", {31'h0, instr_ready}, 32'd1);
        issue(6'd1, 2'd3, 2'd1, 2'd1, 8'h00, 1'b0, 1'b1, 1'b1);
        check("sub_alu_b", {24'h0, alu_b}, 32'h7F);
        repeat (2) @(negedge clk);
        check_reg("sub_r3", 2'd3, 8'h00);
        check("sub_flags", {28'h0, flags}, 32'h4);
        check_reg("sub_r1_kept", 2'd1, 8'h7F);

        // Compare: flags only, destination untouched.
        issue(6'd0, 2'd2, 2'd2, 2'd0, 8'h80, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_reg("cmp_r2", 2'd2, 8'h80);
        check("cmp_flags", {28'h0, flags}, 32'h6);

        // Busy hold: valid stays high for 6 edges.
        acc_cnt    = 0;
        wb_cnt     = 0;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        instr_op    = 6'd10;
        instr_rd    = 2'd0;
        instr_ra    = 2'd0;
        instr_rb    = 2'd0;
        instr_imm   = 8'h11;
        instr_bsel  = 1'b1;
        instr_we    = 1'b1;
        instr_fe    = 1'b0;
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) instr_valid = 1'b0;
            if (instr_valid && instr_ready) begin
                if (acc_cnt < 2) acc_cyc[acc_cnt] = c;
                acc_cnt++;
            end
            if (wb_valid) wb_cnt++;
            @(negedge clk);
        end
        check("hold_accepts", acc_cnt, 32'd2);
        check("hold_spacing", acc_cyc[1] - acc_cyc[0], 32'd3);
        check("hold_wb_pulses", wb_cnt, 32'd2);
        check_reg("hold_r0", 2'd0, 8'h11);

        // Reset during EXEC drops the in-flight instruction.
        issue(6'd10, 2'd0, 2'd0, 2'd0, 8'h55, 1'b1, 1'b1, 1'b1);
        rst_n  = 1'b0;
        wb_cnt = 0;
        @(negedge clk);
        check("mid_rst_wb_rd", {30'h0, wb_rd}, 32'd0);
        check("mid_rst_ready", {31'h0, instr_ready}, 32'd0);
        if (wb_valid) wb_cnt++;
        @(negedge clk);
        if (wb_valid) wb_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_valid) wb_cnt++;
        end
        check("mid_rst_no_wb", wb_cnt, 32'd0);
        check_reg("mid_rst_r0", 2'd0, 8'h00);
        check("mid_rst_flags", {28'h0, flags}, 32'h0);
        issue(6'd10, 2'd3, 2'd0, 2'd0, 8'h3C, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_reg("post_rst_r3", 2'd3, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
